// File: rtl/mem_wb_stage.sv
// MEM/WB end of the pipeline: LW/SW against a local word memory,
// then the register-file write-back bundle two cycles later.
module mem_wb_stage #(
  parameter int PC_WIDTH = 32,
  parameter int AWIDTH   = 5,
  parameter int DWIDTH   = 32,
  parameter int DEPTH    = 6,
  localparam int OPCODE_WIDTH = 6
) (
  input  logic                    m_clk,
  input  logic                    m_rst,
  input  logic                    m_i_ce,
  input  logic [OPCODE_WIDTH-1:0] m_i_opcode,
  input  logic [DWIDTH-1:0]       m_i_alu_value,
  input  logic [DWIDTH-1:0]       m_i_rs2_data,
  input  logic [AWIDTH-1:0]       m_i_rd_addr,
  input  logic [PC_WIDTH-1:0]     m_i_pc,
  output logic                    m_o_ce,
  output logic                    m_o_wb_we,
  output logic [AWIDTH-1:0]       m_o_wb_addr,
  output logic [DWIDTH-1:0]       m_o_wb_data,
  output logic [PC_WIDTH-1:0]     m_o_pc,
  output logic                    m_o_misaligned
);

  localparam logic [OPCODE_WIDTH-1:0] OP_LW = 6'h23;
  localparam logic [OPCODE_WIDTH-1:0] OP_SW = 6'h2B;

  typedef enum logic [1:0] {
    CL_NOP,
    CL_ALU,
    CL_LW,
    CL_SW
  } cls_e;

  logic [DWIDTH-1:0] ram [2**DEPTH];

  cls_e             cls;
  logic             is_alu;
  logic             mis;
  logic [DEPTH-1:0] idx;

  logic                mem_v;
  cls_e                mem_cls;
  logic [AWIDTH-1:0]   mem_rd;
  logic [PC_WIDTH-1:0] mem_pc;
  logic [DWIDTH-1:0]   mem_alu;
  logic [DWIDTH-1:0]   mem_rdata;
  logic                mem_mis;
  logic                wb_wr;

  assign idx    = m_i_alu_value[DEPTH+1:2];
  assign is_alu = (m_i_opcode == 6'h00) ||
                  (m_i_opcode >= 6'h08 && m_i_opcode <= 6'h0F);

  always_comb begin
    cls = CL_NOP;
    unique case (1'b1)
      (m_i_opcode == OP_LW): cls = CL_LW;
      (m_i_opcode == OP_SW): cls = CL_SW;
      is_alu:                cls = CL_ALU;
      default:               cls = CL_NOP;
    endcase
  end

  assign mis = (cls == CL_LW || cls == CL_SW) &&
               (m_i_alu_value[1:0] != 2'b00);

  // Store writes and load reads share the accept edge, so an SW at N
  // is visible to an LW accepted at N+1.
  always_ff @(posedge m_clk) begin
    if (m_rst) begin
      ram   <= '{default: '0};
      mem_v <= 1'b0;
    end else begin
      mem_v <= m_i_ce;
      if (m_i_ce) begin
        mem_cls <= cls;
        mem_rd  <= m_i_rd_addr;
        mem_pc  <= m_i_pc;
        mem_alu <= m_i_alu_value;
        mem_mis <= mis;
        if (cls == CL_SW && !mis)
          ram[idx] <= m_i_rs2_data;
        if (cls == CL_LW)
          mem_rdata <= ram[idx];
      end
    end
  end

  assign wb_wr = (mem_cls == CL_LW || mem_cls == CL_ALU) &&
                 (mem_rd != '0) && !mem_mis;

  always_ff @(posedge m_clk) begin
    if (m_rst) begin
      m_o_ce         <= 1'b0;
      m_o_wb_we      <= 1'b0;
      m_o_wb_addr    <= '0;
      m_o_wb_data    <= '0;
      m_o_pc         <= '0;
      m_o_misaligned <= 1'b0;
    end else begin
      m_o_ce         <= mem_v;
      m_o_wb_we      <= mem_v && wb_wr;
      m_o_misaligned <= mem_v && mem_mis;
      if (mem_v) begin
        m_o_wb_addr <= mem_rd;
        m_o_wb_data <= (mem_cls == CL_LW) ? mem_rdata : mem_alu;
        m_o_pc      <= mem_pc;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed checks of mem_wb_stage: reset, store/load, wrap,
// misalignment, ALU/rd0/no-op write-back, bubbles, mid-flight reset.
module tb_mem_wb_stage;

  localparam logic [5:0] LW  = 6'h23;
  localparam logic [5:0] SW  = 6'h2B;
  localparam logic [5:0] RT  = 6'h00;
  localparam logic [5:0] LUI = 6'h0F;
  localparam logic [5:0] BEQ = 6'h04;
  localparam logic [5:0] OTH = 6'h10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_ce = 1'b0;
  logic [5:0]  i_op = 6'h3F;
  logic [31:0] i_alu = '0;
  logic [31:0] i_rs2 = '0;
  logic [4:0]  i_rd = '0;
  logic [31:0] i_pc = '0;
  logic        o_ce;
  logic        o_we;
  logic [4:0]  o_addr;
  logic [31:0] o_data;
  logic [31:0] o_pc;
  logic        o_mis;

  int checks = 0;
  int errors = 0;
  logic [31:0] pc_ctr = 32'h100;
  logic [31:0] saved_pc;

  mem_wb_stage dut (
    .m_clk          (clk),
    .m_rst          (rst),
    .m_i_ce         (i_ce),
    .m_i_opcode     (i_op),
    .m_i_alu_value  (i_alu),
    .m_i_rs2_data   (i_rs2),
    .m_i_rd_addr    (i_rd),
    .m_i_pc         (i_pc),
    .m_o_ce         (o_ce),
    .m_o_wb_we      (o_we),
    .m_o_wb_addr    (o_addr),
    .m_o_wb_data    (o_data),
    .m_o_pc         (o_pc),
    .m_o_misaligned (o_mis)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  // Outputs only move at posedge, so sampling right after the
  // negedge drive still reflects the previous cycle's state.
  task automatic issue(input logic ce, input logic [5:0] op,
                       input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [4:0] rd);
    @(negedge clk);
    pc_ctr = pc_ctr + 32'd4;
    i_ce  = ce;
    i_op  = op;
    i_alu = alu;
    i_rs2 = rs2;
    i_rd  = rd;
    i_pc  = pc_ctr;
  endtask

  task automatic idle;
    issue(1'b0, RT, 32'h0, 32'h0, 5'd0);
  endtask

  initial begin
    // reset held for two edges with live SW traffic
    issue(1'b1, SW, 32'h10, $urandom, 5'($urandom));
    issue(1'b1, SW, $urandom, $urandom, 5'($urandom));
    issue(1'b1, LW, 32'h10, 32'h0, 5'd1);
    rst = 1'b0;
    chk("rst_ce", 32'(o_ce), 32'd0);
    chk("rst_we", 32'(o_we), 32'd0);
    chk("rst_addr", 32'(o_addr), 32'd0);
    chk("rst_data", o_data, 32'd0);
    chk("rst_pc", o_pc, 32'd0);
    chk("rst_mis", 32'(o_mis), 32'd0);
    saved_pc = pc_ctr;
    idle;
    idle;
    chk("lw0_ce", 32'(o_ce), 32'd1);
    chk("lw0_we", 32'(o_we), 32'd1);
    chk("lw0_data", o_data, 32'd0);
    chk("lw0_pc", o_pc, saved_pc);

    // store then immediate load of the same word
    issue(1'b1, SW, 32'h08, 32'hDEADBEEF, 5'd9);
    issue(1'b1, LW, 32'h08, 32'h0, 5'd5);
    idle;
    chk("sw_ce", 32'(o_ce), 32'd1);
    chk("sw_we", 32'(o_we), 32'd0);
    chk("sw_mis", 32'(o_mis), 32'd0);
    idle;
    chk("ld_ce", 32'(o_ce), 32'd1);
    chk("ld_we", 32'(o_we), 32'd1);
    chk("ld_addr", 32'(o_addr), 32'd5);
    chk("ld_data", o_data, 32'hDEADBEEF);

    // 0x100 aliases word 0 with 64 words
    issue(1'b1, SW, 32'h100, 32'h1234, 5'd0);
    issue(1'b1, LW, 32'h000, 32'h0, 5'd6);
    idle;
    idle;
    chk("wrap_data", o_data, 32'h1234);
    chk("wrap_we", 32'(o_we), 32'd1);

    // misaligned store must not write word 6
    issue(1'b1, SW, 32'h1A, 32'hFFFF, 5'd0);
    issue(1'b1, LW, 32'h18, 32'h0, 5'd7);
    issue(1'b1, LW, 32'h0A, 32'h0, 5'd8);
    chk("msw_mis", 32'(o_mis), 32'd1);
    chk("msw_we", 32'(o_we), 32'd0);
    idle;
    chk("mld_data", o_data, 32'd0);
    chk("mld_we", 32'(o_we), 32'd1);
    chk("mld_mis", 32'(o_mis), 32'd0);
    idle;
    chk("mlw_ce", 32'(o_ce), 32'd1);
    chk("mlw_we", 32'(o_we), 32'd0);
    chk("mlw_mis", 32'(o_mis), 32'd1);

    // ALU write-back, rd0 suppression, no-op opcodes
    issue(1'b1, RT, 32'd7, 32'h0, 5'd3);
    issue(1'b1, RT, 32'd7, 32'h0, 5'd0);
    issue(1'b1, BEQ, 32'h3, 32'h0, 5'd2);
    chk("alu_we", 32'(o_we), 32'd1);
    chk("alu_addr", 32'(o_addr), 32'd3);
    chk("alu_data", o_data, 32'd7);
    issue(1'b1, LUI, 32'hABCD0000, 32'h0, 5'd4);
    chk("rd0_ce", 32'(o_ce), 32'd1);
    chk("rd0_we", 32'(o_we), 32'd0);
    issue(1'b1, OTH, 32'h55, 32'h0, 5'd4);
    chk("beq_ce", 32'(o_ce), 32'd1);
    chk("beq_we", 32'(o_we), 32'd0);
    chk("beq_mis", 32'(o_mis), 32'd0);
    idle;
    chk("lui_we", 32'(o_we), 32'd1);
    chk("lui_data", o_data, 32'hABCD0000);
    idle;
    chk("oth_ce", 32'(o_ce), 32'd1);
    chk("oth_we", 32'(o_we), 32'd0);

    // bubble pattern 1,0,1
    issue(1'b1, RT, 32'h11, 32'h0, 5'd12);
    issue(1'b0, RT, 32'h22, 32'h0, 5'd13);
    issue(1'b1, RT, 32'h33, 32'h0, 5'd14);
    chk("bub_a_ce", 32'(o_ce), 32'd1);
    idle;
    chk("bub_b_ce", 32'(o_ce), 32'd0);
    chk("bub_b_we", 32'(o_we), 32'd0);
    chk("bub_b_hold", 32'(o_addr), 32'd12);
    idle;
    chk("bub_c_ce", 32'(o_ce), 32'd1);
    chk("bub_c_data", o_data, 32'h33);

    // reset while an SW and an LW are in flight
    issue(1'b1, SW, 32'h20, 32'h5555, 5'd0);
    issue(1'b1, LW, 32'h20, 32'h0, 5'd9);
    idle;
    rst = 1'b1;
    idle;
    chk("mrst_ce0", 32'(o_ce), 32'd0);
    chk("mrst_we0", 32'(o_we), 32'd0);
    rst = 1'b0;
    idle;
    idle;
    chk("mrst_ce1", 32'(o_ce), 32'd0);
    issue(1'b1, LW, 32'h20, 32'h0, 5'd9);
    idle;
    chk("mrst_ce2", 32'(o_ce), 32'd0);
    idle;
    chk("mrst_ld_ce", 32'(o_ce), 32'd1);
    chk("mrst_ld_data", o_data, 32'd0);
    chk("mrst_ld_addr", 32'(o_addr), 32'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
